si_requant_pipe: RTL

//  Pipelined, multi-channel, streaming requantizer. Converts a signed N_IN-bit accumulator to a

---
 rtl/si_quant_pkg.sv | 23 ++
 rtl/si_round_sat.sv | 52 +++++
 rtl/si_requant_pipe.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/si_quant_pkg.sv
// Shared types and helpers for the si_requant_pipe requantizer.
package si_quant_pkg;

  localparam int M0_FRAC_BITS = 32;
  localparam int SHIFT_W      = 5;
  localparam int OFF_W        = 32;

  // Offset is kept sign-extended to OFF_W so the entry layout does not depend on N_OUT.
  typedef struct packed {
    logic [M0_FRAC_BITS-1:0] m0;
    logic [SHIFT_W-1:0]      shift;
    logic [OFF_W-1:0]        offset;
  } cfg_t;

  function automatic int sat_min(input int n_out);
    return -(32'sd1 <<< (n_out - 1));
  endfunction

  function automatic int sat_max(input int n_out);
    return (32'sd1 <<< (n_out - 1)) - 32'sd1;
  endfunction

endpackage

// File: rtl/si_round_sat.sv
// Combinational last stage: round half away from zero, restore sign, add zero-point, clamp.
module si_round_sat
  import si_quant_pkg::*;
#(
  parameter int N_IN  = 32,
  parameter int N_OUT = 8
) (
  input  logic [N_IN+M0_FRAC_BITS-1:0] i_prod,
  input  logic                         i_sign,
  input  logic [SHIFT_W-1:0]           i_shift,
  input  logic signed [OFF_W-1:0]      i_offset,
  output logic [N_OUT-1:0]             o_data,
  output logic                         o_sat
);

  localparam int PW = N_IN + M0_FRAC_BITS;
  localparam int RW = PW + 2;
  localparam logic signed [RW-1:0] L_MIN = RW'(sat_min(N_OUT));
  localparam logic signed [RW-1:0] L_MAX = RW'(sat_max(N_OUT));

  logic [PW-1:0]        w_half;
  logic [PW:0]          w_q;
  logic signed [RW-1:0] w_qs;
  logic signed [RW-1:0] w_v;
  logic signed [RW-1:0] w_off;
  logic signed [RW-1:0] w_r;

  // Stop one bit early so the LSB is the rounding bit and the rest is the truncated quotient.
  assign w_half = i_prod >> ({2'b00, i_shift} + 7'd31);
  assign w_q    = {1'b0, w_half[PW-1:1]} + {{PW{1'b0}}, w_half[0]};
  assign w_qs   = $signed({1'b0, w_q});
  assign w_v    = i_sign ? -w_qs : w_qs;
  assign w_off  = {{(RW-OFF_W){i_offset[OFF_W-1]}}, i_offset};
  assign w_r    = w_v + w_off;

  // Clamp to the signed output range and flag clipping.
  always_comb begin
    o_data = w_r[N_OUT-1:0];
    o_sat  = 1'b0;
    if (w_r < L_MIN) begin
      o_data = L_MIN[N_OUT-1:0];
      o_sat  = 1'b1;
    end else if (w_r > L_MAX) begin
      o_data = L_MAX[N_OUT-1:0];
      o_sat  = 1'b1;
    end else begin
      o_data = w_r[N_OUT-1:0];
      o_sat  = 1'b0;
    end
  end

endmodule

// File: rtl/si_requant_pipe.sv
// Three-stage streaming requantizer with per-channel M0/SHIFT/OFFSET and valid/ready on both sides.
// Optional saturation counter enabled by defining SI_REQUANT_SATCNT_EN.
module si_requant_pipe
  import si_quant_pkg::*;
#(
  parameter int          N_IN       = 32,
  parameter int          N_OUT      = 8,
  parameter int          N_CH       = 4,
  parameter logic [31:0] DEF_M0     = 32'd1932735283,
  parameter int          DEF_SHIFT  = 10,
  parameter int          DEF_OFFSET = 22
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN-1:0]         in_data,
  input  logic [$clog2(N_CH)-1:0] in_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT-1:0]        out_data,
  output logic [$clog2(N_CH)-1:0] out_ch,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [31:0]             cfg_m0,
  input  logic [4:0]              cfg_shift,
  input  logic [N_OUT-1:0]        cfg_offset,
  output logic [15:0]             sat_count
);

  localparam int CH_W = $clog2(N_CH);
  localparam int PW   = N_IN + M0_FRAC_BITS;
  localparam logic [CH_W:0] L_NCH = (CH_W+1)'(N_CH);
  localparam cfg_t L_DEF = '{
    m0:     DEF_M0,
    shift:  SHIFT_W'(DEF_SHIFT),
    offset: OFF_W'(DEF_OFFSET)
  };

  cfg_t              r_cfg [N_CH];
  cfg_t              w_rd_cfg;
  logic [CH_W-1:0]   w_rd_idx;
  logic [N_IN-1:0]   w_mag;
  logic              w_adv;

  logic              r_s1_valid;
  logic              r_s1_sign;
  logic [N_IN-1:0]   r_s1_mag;
  logic [CH_W-1:0]   r_s1_ch;
  cfg_t              r_s1_cfg;

  logic              r_s2_valid;
  logic              r_s2_sign;
  logic [PW-1:0]     r_s2_prod;
  logic [SHIFT_W-1:0] r_s2_shift;
  logic [OFF_W-1:0]  r_s2_offset;
  logic [CH_W-1:0]   r_s2_ch;

  logic              r_out_valid;
  logic [N_OUT-1:0]  r_out_data;
  logic [CH_W-1:0]   r_out_ch;

  logic [N_OUT-1:0]  w_data;
  logic              w_sat;

  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

  // Out-of-range channels fall back to entry 0; the tag itself is passed through untouched.
  assign w_rd_idx = ({1'b0, in_ch} < L_NCH) ? in_ch : {CH_W{1'b0}};
  assign w_rd_cfg = r_cfg[w_rd_idx];
  assign w_mag    = in_data[N_IN-1] ? (~in_data + {{(N_IN-1){1'b0}}, 1'b1}) : in_data;

  // Per-channel configuration file; a same-cycle write is seen only by later samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        r_cfg[i] <= L_DEF;
      end
    end else if (cfg_we && ({1'b0, cfg_ch} < L_NCH)) begin
      r_cfg[cfg_ch] <= '{
        m0:     cfg_m0,
        shift:  cfg_shift,
        offset: OFF_W'($signed(cfg_offset))
      };
    end
  end

  // Lock-step pipeline: every stage advances together whenever the output can move.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_mag    <= {N_IN{1'b0}};
      r_s1_ch     <= {CH_W{1'b0}};
      r_s1_cfg    <= L_DEF;
      r_s2_valid  <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_prod   <= {PW{1'b0}};
      r_s2_shift  <= {SHIFT_W{1'b0}};
      r_s2_offset <= {OFF_W{1'b0}};
      r_s2_ch     <= {CH_W{1'b0}};
      r_out_valid <= 1'b0;
      r_out_data  <= {N_OUT{1'b0}};
      r_out_ch    <= {CH_W{1'b0}};
    end else if (w_adv) begin
      r_s1_valid  <= in_valid;
      r_s1_sign   <= in_data[N_IN-1];
      r_s1_mag    <= w_mag;
      r_s1_ch     <= in_ch;
      r_s1_cfg    <= w_rd_cfg;
      r_s2_valid  <= r_s1_valid;
      r_s2_sign   <= r_s1_sign;
      r_s2_prod   <= {{M0_FRAC_BITS{1'b0}}, r_s1_mag} * {{N_IN{1'b0}}, r_s1_cfg.m0};
      r_s2_shift  <= r_s1_cfg.shift;
      r_s2_offset <= r_s1_cfg.offset;
      r_s2_ch     <= r_s1_ch;
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_data <= w_data;
        r_out_ch   <= r_s2_ch;
      end
    end
  end

  si_round_sat #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_round_sat (
    .i_prod   (r_s2_prod),
    .i_sign   (r_s2_sign),
    .i_shift  (r_s2_shift),
    .i_offset (r_s2_offset),
    .o_data   (w_data),
    .o_sat    (w_sat)
  );

`ifdef SI_REQUANT_SATCNT_EN
  logic [15:0] r_sat_count;

  // Counts clipped results as they enter the output register, sticking at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sat_count <= 16'h0000;
    end else if (w_adv && r_s2_valid && w_sat && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'h0001;
    end
  end

  assign sat_count = r_sat_count;
`else
  assign sat_count = 16'h0000;
`endif

endmodule
